axi_default_slave: RTL and testbench

AXI default slave (DS) for the interconnect: it receives every read or write whose address decodes to no mapped slave, and answers with DECERR responses. It sits directly upstream of the read-data mux and drives its DS_RID/DS_RData/DS_RStrb/DS_RLast/DS_RValid inputs, consuming DS_RReady. It also terminates the AW/W/B channels for unmapped writes, so that no master ever hangs on a bad address.

---
 rtl/axi_default_slave_pkg.sv | 40 ++++
 rtl/axi_default_slave_ds_err_counter.sv | 33 +++
 rtl/axi_default_slave.sv | 157 +++++++++++++++
 tb/tb_axi_default_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_default_slave_pkg.sv
// Shared AXI definitions for the default slave: bus widths, response codes
// and the read/write FSM state types.
// The width macros may be overridden on the command line; defaults below.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_default_slave_pkg;

  localparam int IDS_W  = `AXI_IDS_BITS;
  localparam int LEN_W  = `AXI_LEN_BITS;
  localparam int DATA_W = `AXI_DATA_BITS;
  localparam int STRB_W = `AXI_STRB_BITS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

endpackage

// File: rtl/axi_default_slave_ds_err_counter.sv
// Saturating 16-bit DECERR counter. Two independent increment strobes so a
// read completion and a write completion in the same cycle both count.

module ds_err_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        incA_i,
  input  logic        incB_i,
  output logic [15:0] count_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [16:0] sum;

  // Add both strobes in 17 bits and clamp at all-ones on overflow
  always_comb begin
    sum   = {1'b0, cnt_q} + 17'(incA_i) + 17'(incB_i);
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  // Counter register, cleared by the synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/axi_default_slave.sv
// AXI default slave: answers every unmapped read/write with DECERR.
// Independent read (R_IDLE/R_BURST) and write (W_IDLE/W_DATA/W_RESP) FSMs,
// one outstanding transaction per direction. All outputs decode from state.
// Optional feature: define DS_ERR_CNT_EN to add the DS_ErrCnt port.

module axi_default_slave
  import axi_default_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  DS_ARID,
  input  logic [LEN_W-1:0]  DS_ARLen,
  input  logic              DS_ARValid,
  output logic              DS_ARReady,
  output logic [IDS_W-1:0]  DS_RID,
  output logic [DATA_W-1:0] DS_RData,
  output logic [STRB_W-1:0] DS_RStrb,
  output logic [1:0]        DS_RResp,
  output logic              DS_RLast,
  output logic              DS_RValid,
  input  logic              DS_RReady,
  input  logic [IDS_W-1:0]  DS_AWID,
  input  logic              DS_AWValid,
  output logic              DS_AWReady,
  input  logic              DS_WLast,
  input  logic              DS_WValid,
  output logic              DS_WReady,
  output logic [IDS_W-1:0]  DS_BID,
  output logic [1:0]        DS_BResp,
  output logic              DS_BValid,
  input  logic              DS_BReady
`ifdef DS_ERR_CNT_EN
  ,
  output logic [15:0]       DS_ErrCnt
`endif
);

  r_state_t         rState_q, rState_d;
  logic [IDS_W-1:0] rId_q, rId_d;
  logic [LEN_W-1:0] rLen_q, rLen_d;
  logic [LEN_W-1:0] rCnt_q, rCnt_d;

  w_state_t         wState_q, wState_d;
  logic [IDS_W-1:0] wId_q, wId_d;

  // Read channel outputs: pure decode of the read FSM registers
  assign DS_ARReady = (rState_q == R_IDLE);
  assign DS_RValid  = (rState_q == R_BURST);
  assign DS_RLast   = (rState_q == R_BURST) && (rCnt_q == rLen_q);
  assign DS_RID     = rId_q;
  assign DS_RData   = '0;
  assign DS_RStrb   = '0;
  assign DS_RResp   = RESP_DECERR;

  // Write channel outputs: pure decode of the write FSM registers
  assign DS_AWReady = (wState_q == W_IDLE);
  assign DS_WReady  = (wState_q == W_DATA);
  assign DS_BValid  = (wState_q == W_RESP);
  assign DS_BID     = wId_q;
  assign DS_BResp   = RESP_DECERR;

  // Read FSM registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rState_q <= R_IDLE;
      rId_q    <= '0;
      rLen_q   <= '0;
      rCnt_q   <= '0;
    end else begin
      rState_q <= rState_d;
      rId_q    <= rId_d;
      rLen_q   <= rLen_d;
      rCnt_q   <= rCnt_d;
    end
  end

  // Read next state: capture AR, then count beats up to the captured length
  always_comb begin
    rState_d = rState_q;
    rId_d    = rId_q;
    rLen_d   = rLen_q;
    rCnt_d   = rCnt_q;
    case (rState_q)
      R_IDLE: begin
        if (DS_ARValid) begin
          rId_d    = DS_ARID;
          rLen_d   = DS_ARLen;
          rCnt_d   = '0;
          rState_d = R_BURST;
        end
      end
      R_BURST: begin
        if (DS_RReady) begin
          if (rCnt_q == rLen_q) begin
            rState_d = R_IDLE;
          end else begin
            rCnt_d = rCnt_q + LEN_W'(1);
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Write FSM registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wState_q <= W_IDLE;
      wId_q    <= '0;
    end else begin
      wState_q <= wState_d;
      wId_q    <= wId_d;
    end
  end

  // Write next state: capture AW, sink beats until WLast, then issue B
  always_comb begin
    wState_d = wState_q;
    wId_d    = wId_q;
    case (wState_q)
      W_IDLE: begin
        if (DS_AWValid) begin
          wId_d    = DS_AWID;
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        if (DS_WValid && DS_WLast) begin
          wState_d = W_RESP;
        end
      end
      W_RESP: begin
        if (DS_BReady) begin
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

`ifdef DS_ERR_CNT_EN
  logic rDone;
  logic bDone;

  assign rDone = DS_RValid && DS_RReady && DS_RLast;
  assign bDone = DS_BValid && DS_BReady;

  ds_err_counter u_errCnt (
    .clk     (clk),
    .rst     (rst),
    .incA_i  (rDone),
    .incB_i  (bDone),
    .count_o (DS_ErrCnt)
  );
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Scoreboard bench for axi_default_slave. Stimulus tasks push expected R
// beats / B responses into queues; a negedge monitor pops and compares on
// every completed handshake. Counter checks only when DS_ERR_CNT_EN is set.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_axi_default_slave;

  logic                       clk;
  logic                       rst;
  logic [`AXI_IDS_BITS-1:0]   DS_ARID;
  logic [`AXI_LEN_BITS-1:0]   DS_ARLen;
  logic                       DS_ARValid;
  logic                       DS_ARReady;
  logic [`AXI_IDS_BITS-1:0]   DS_RID;
  logic [`AXI_DATA_BITS-1:0]  DS_RData;
  logic [`AXI_STRB_BITS-1:0]  DS_RStrb;
  logic [1:0]                 DS_RResp;
  logic                       DS_RLast;
  logic                       DS_RValid;
  logic                       DS_RReady;
  logic [`AXI_IDS_BITS-1:0]   DS_AWID;
  logic                       DS_AWValid;
  logic                       DS_AWReady;
  logic                       DS_WLast;
  logic                       DS_WValid;
  logic                       DS_WReady;
  logic [`AXI_IDS_BITS-1:0]   DS_BID;
  logic [1:0]                 DS_BResp;
  logic                       DS_BValid;
  logic                       DS_BReady;
`ifdef DS_ERR_CNT_EN
  logic [15:0]                DS_ErrCnt;
`endif

  typedef struct packed {
    logic [7:0] id;
    logic       last;
  } rBeat_t;

  rBeat_t     rExp[$];
  logic [7:0] bExp[$];
  int         total = 0;
  int         bad   = 0;
  int         rHs   = 0;

  axi_default_slave dut (
    .clk        (clk),
    .rst        (rst),
    .DS_ARID    (DS_ARID),
    .DS_ARLen   (DS_ARLen),
    .DS_ARValid (DS_ARValid),
    .DS_ARReady (DS_ARReady),
    .DS_RID     (DS_RID),
    .DS_RData   (DS_RData),
    .DS_RStrb   (DS_RStrb),
    .DS_RResp   (DS_RResp),
    .DS_RLast   (DS_RLast),
    .DS_RValid  (DS_RValid),
    .DS_RReady  (DS_RReady),
    .DS_AWID    (DS_AWID),
    .DS_AWValid (DS_AWValid),
    .DS_AWReady (DS_AWReady),
    .DS_WLast   (DS_WLast),
    .DS_WValid  (DS_WValid),
    .DS_WReady  (DS_WReady),
    .DS_BID     (DS_BID),
    .DS_BResp   (DS_BResp),
    .DS_BValid  (DS_BValid),
    .DS_BReady  (DS_BReady)
`ifdef DS_ERR_CNT_EN
    ,
    .DS_ErrCnt  (DS_ErrCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed R or B handshake is matched against the scoreboard
  always @(negedge clk) begin
    rBeat_t e;
    logic [7:0] b;
    if (rst && DS_RValid && DS_RReady) begin
      rHs++;
      if (rExp.size() == 0) begin
        checkOutput("rStaleBeat", 32'(DS_RID), 32'hFFFF_FFFF);
      end else begin
        e = rExp.pop_front();
        checkOutput("rId", 32'(DS_RID), 32'(e.id));
        checkOutput("rLast", 32'(DS_RLast), 32'(e.last));
        checkOutput("rResp", 32'(DS_RResp), 32'h3);
        checkOutput("rData", 32'(DS_RData), 32'h0);
        checkOutput("rStrb", 32'(DS_RStrb), 32'h0);
      end
    end
    if (rst && DS_BValid && DS_BReady) begin
      if (bExp.size() == 0) begin
        checkOutput("bStale", 32'(DS_BID), 32'hFFFF_FFFF);
      end else begin
        b = bExp.pop_front();
        checkOutput("bId", 32'(DS_BID), 32'(b));
        checkOutput("bResp", 32'(DS_BResp), 32'h3);
      end
    end
  end

  // Issue one AR and queue its expected beats; returns just after the handshake edge
  task automatic applyStimulus(input logic [7:0] id, input logic [3:0] len);
    int n = 0;
    DS_ARValid = 1'b1;
    DS_ARID    = id;
    DS_ARLen   = len;
    for (int i = 0; i <= int'(len); i++) rExp.push_back('{id: id, last: (i == int'(len))});
    @(negedge clk);
    while (!DS_ARReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("arReady", 32'(DS_ARReady), 32'h1);
    @(posedge clk);
    #1;
    DS_ARValid = 1'b0;
  endtask

  task automatic sendAw(input logic [7:0] id);
    int n = 0;
    DS_AWValid = 1'b1;
    DS_AWID    = id;
    bExp.push_back(id);
    @(negedge clk);
    while (!DS_AWReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("awReady", 32'(DS_AWReady), 32'h1);
    @(posedge clk);
    #1;
    DS_AWValid = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs0;
    logic [7:0] rrPat [8];
    rrPat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
    rst = 1'b0;
    DS_ARID = '0; DS_ARLen = '0; DS_ARValid = 1'b0; DS_RReady = 1'b0;
    DS_AWID = '0; DS_AWValid = 1'b0; DS_WLast = 1'b0; DS_WValid = 1'b0; DS_BReady = 1'b0;

    // Reset state
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rstArReady", 32'(DS_ARReady), 32'h1);
    checkOutput("rstAwReady", 32'(DS_AWReady), 32'h1);
    checkOutput("rstWReady", 32'(DS_WReady), 32'h0);
    checkOutput("rstRValid", 32'(DS_RValid), 32'h0);
    checkOutput("rstRLast", 32'(DS_RLast), 32'h0);
    checkOutput("rstBValid", 32'(DS_BValid), 32'h0);
    checkOutput("rstRId", 32'(DS_RID), 32'h0);
    checkOutput("rstBId", 32'(DS_BID), 32'h0);
    checkOutput("rstRResp", 32'(DS_RResp), 32'h3);
    checkOutput("rstBResp", 32'(DS_BResp), 32'h3);
`ifdef DS_ERR_CNT_EN
    checkOutput("rstErrCnt", 32'(DS_ErrCnt), 32'h0);
`endif
    nextCycle();
    rst = 1'b1;

    // Single-beat read
    $display("[TB] single-beat read");
    DS_RReady = 1'b1;
    applyStimulus(8'h13, 4'd0);
    @(negedge clk);
    checkOutput("t1RValid", 32'(DS_RValid), 32'h1);
    checkOutput("t1ArReadyBusy", 32'(DS_ARReady), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1RValidDone", 32'(DS_RValid), 32'h0);
    checkOutput("t1ArReadyBack", 32'(DS_ARReady), 32'h1);
    nextCycle();

    // 4-beat read with RReady stalls on beats 2 and 3
    $display("[TB] 4-beat stalled read");
    hs0 = rHs;
    applyStimulus(8'h21, 4'd3);
    for (int i = 0; i < 8; i++) begin
      DS_RReady = rrPat[i][0];
      @(negedge clk);
      checkOutput("t2RValid", 32'(DS_RValid), 32'h1);
      if (!DS_RReady) begin
        checkOutput("t2StallId", 32'(DS_RID), 32'h21);
        checkOutput("t2StallLast", 32'(DS_RLast), 32'h0);
      end
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t2Handshakes", 32'(rHs - hs0), 32'd4);
    checkOutput("t2RValidDone", 32'(DS_RValid), 32'h0);
    checkOutput("t2ArReadyBack", 32'(DS_ARReady), 32'h1);
    nextCycle();

    // Write burst of 3 beats, B held until BReady
    $display("[TB] write burst");
    DS_BReady = 1'b0;
    sendAw(8'h2A);
    for (int i = 0; i < 3; i++) begin
      DS_WValid = 1'b1;
      DS_WLast  = (i == 2);
      @(negedge clk);
      checkOutput("t3WReady", 32'(DS_WReady), 32'h1);
      checkOutput("t3BValidEarly", 32'(DS_BValid), 32'h0);
      nextCycle();
    end
    DS_WValid = 1'b0;
    DS_WLast  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t3WReadyOff", 32'(DS_WReady), 32'h0);
      checkOutput("t3BValidHeld", 32'(DS_BValid), 32'h1);
      checkOutput("t3BId", 32'(DS_BID), 32'h2A);
      nextCycle();
    end
    DS_BReady = 1'b1;
    nextCycle();
    DS_BReady = 1'b0;
    @(negedge clk);
    checkOutput("t3BValidDone", 32'(DS_BValid), 32'h0);
    checkOutput("t3AwReadyBack", 32'(DS_AWReady), 32'h1);
`ifdef DS_ERR_CNT_EN
    checkOutput("t3ErrCnt", 32'(DS_ErrCnt), 32'd3);
`endif
    nextCycle();

    // Concurrent 2-beat read and 1-beat write; R-last and B finish together
    $display("[TB] concurrent read and write");
    DS_RReady  = 1'b1;
    DS_BReady  = 1'b1;
    DS_ARValid = 1'b1; DS_ARID = 8'h35; DS_ARLen = 4'd1;
    DS_AWValid = 1'b1; DS_AWID = 8'h46;
    rExp.push_back('{id: 8'h35, last: 1'b0});
    rExp.push_back('{id: 8'h35, last: 1'b1});
    bExp.push_back(8'h46);
    @(negedge clk);
    checkOutput("t4ArReady", 32'(DS_ARReady), 32'h1);
    checkOutput("t4AwReady", 32'(DS_AWReady), 32'h1);
    nextCycle();
    DS_ARValid = 1'b0;
    DS_AWValid = 1'b0;
    DS_WValid  = 1'b1;
    DS_WLast   = 1'b1;
    @(negedge clk);
    checkOutput("t4WReady", 32'(DS_WReady), 32'h1);
    nextCycle();
    DS_WValid = 1'b0;
    DS_WLast  = 1'b0;
    @(negedge clk);
    checkOutput("t4BothLastR", 32'(DS_RLast), 32'h1);
    checkOutput("t4BothBValid", 32'(DS_BValid), 32'h1);
`ifdef DS_ERR_CNT_EN
    checkOutput("t4ErrCntBefore", 32'(DS_ErrCnt), 32'd3);
`endif
    nextCycle();
    @(negedge clk);
    checkOutput("t4RIdle", 32'(DS_RValid), 32'h0);
    checkOutput("t4BIdle", 32'(DS_BValid), 32'h0);
`ifdef DS_ERR_CNT_EN
    checkOutput("t4ErrCntPlus2", 32'(DS_ErrCnt), 32'd5);
`endif
    DS_BReady = 1'b0;
    nextCycle();

    // Reset during beat 2 of an 8-beat read
    $display("[TB] reset mid-burst");
    applyStimulus(8'h77, 4'd7);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
    rExp.delete();
    @(negedge clk);
    checkOutput("t5RValidAfterRst", 32'(DS_RValid), 32'h0);
    checkOutput("t5ArReadyAfterRst", 32'(DS_ARReady), 32'h1);
`ifdef DS_ERR_CNT_EN
    checkOutput("t5ErrCntRst", 32'(DS_ErrCnt), 32'd0);
`endif
    for (int i = 0; i < 4; i++) nextCycle();
    applyStimulus(8'h10, 4'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t5ArReadyBack", 32'(DS_ARReady), 32'h1);
`ifdef DS_ERR_CNT_EN
    checkOutput("t5ErrCntOne", 32'(DS_ErrCnt), 32'd1);
`endif
    nextCycle();

`ifdef DS_ERR_CNT_EN
    // Saturation: preload near full scale then complete three reads
    $display("[TB] counter saturation");
    force dut.u_errCnt.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.u_errCnt.cnt_q;
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h50 + 8'(i), 4'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("t6ErrCntSat", 32'(DS_ErrCnt), 32'hFFFF);
      nextCycle();
    end
`endif

    // Every queued response must have been seen
    for (int i = 0; i < 5; i++) nextCycle();
    checkOutput("rQueueEmpty", 32'(rExp.size()), 32'd0);
    checkOutput("bQueueEmpty", 32'(bExp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
